// File: rtl/mem_dump_ctrl.sv
// Walks the data memory word by word through the debug read port and streams it out as bytes.
// Optional trailing XOR checksum byte when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_debug_addr,
  output logic                  o_mem_read_en,
  input  logic [DATA_WIDTH-1:0] i_debug_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_dbg_state
);

  // Byte stream: a byte transfers on a posedge where o_tx_valid && i_tx_ready;
  // o_tx_data holds steady while o_tx_valid is high and i_tx_ready is low.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
`ifdef MEM_DUMP_CHECKSUM_EN
    S_CSUM = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 4);
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam state_t AFTER_LAST = S_CSUM;
`else
  localparam state_t AFTER_LAST = S_DONE;
`endif

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            cur_byte;

  assign cur_byte = word[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (i_start) state_n = S_READ;
      S_READ: state_n = S_WAIT;
      S_WAIT: state_n = S_SEND;
      S_SEND: begin
        if (i_tx_ready && byte_idx == 2'd3)
          state_n = (addr == LAST_ADDR) ? AFTER_LAST : S_READ;
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM: if (i_tx_ready) state_n = S_DONE;
`endif
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (i_abort) state_n = S_IDLE;
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      byte_idx <= '0;
      word     <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (!i_abort) begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            addr <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        S_WAIT: begin
          word     <= i_debug_data;
          byte_idx <= 2'd0;
        end
        S_SEND: begin
          if (i_tx_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            csum <= csum ^ cur_byte;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3 && addr != LAST_ADDR)
              addr <= addr + ADDR_WIDTH'(4);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_debug_addr  = addr;
    o_mem_read_en = 1'b0;
    o_tx_data     = 8'h00;
    o_tx_valid    = 1'b0;
    o_busy        = (state != S_IDLE);
    o_done        = 1'b0;
    o_dbg_state   = state;
    case (state)
      S_READ: o_mem_read_en = 1'b1;
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = cur_byte;
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = csum;
      end
`endif
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: memory model, expected byte/address queues, per-cycle compare process.
module tb_mem_dump_ctrl;
  localparam int MEM_SIZE = 64;
  localparam int AW       = 6;
  localparam int WORDS    = MEM_SIZE / 4;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int EXP_BYTES = MEM_SIZE + 1;
`else
  localparam int EXP_BYTES = MEM_SIZE;
`endif

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_abort;
  logic [AW-1:0] o_debug_addr;
  logic          o_mem_read_en;
  logic [31:0]   i_debug_data;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_busy;
  logic          o_done;
  logic [2:0]    o_dbg_state;

  mem_dump_ctrl #(.DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_debug_addr(o_debug_addr), .o_mem_read_en(o_mem_read_en),
    .i_debug_data(i_debug_data), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: captures the addressed word on the falling edge of the read cycle
  logic [7:0] mem [MEM_SIZE];
  always @(negedge clk) begin
    if (o_mem_read_en) begin
      int a;
      a = int'(o_debug_addr);
      i_debug_data = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    end
  end

  // scoreboard
  logic [7:0]    exp_q[$];
  logic [7:0]    act_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int total = 0;
  int bad = 0;
  int hs_cnt, done_cnt, rd_cnt, busy_cycles;
  bit rnd_mode;
  bit prev_stall, prev_abort;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream from the spec: each word's bytes low-to-high, words in address order.
  task automatic load_expected();
    logic [7:0] acc;
    acc = 8'h00;
    exp_q.delete();
    exp_addr_q.delete();
    for (int w = 0; w < WORDS; w++) begin
      exp_addr_q.push_back(AW'(w * 4));
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(mem[w*4+b]);
        acc = acc ^ mem[w*4+b];
      end
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    exp_q.push_back(acc);
`endif
  endtask

  // compare process, mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        check("stall_valid", 32'(o_tx_valid), 32'd1);
        check("stall_data", 32'(o_tx_data), 32'(prev_data));
      end
      if (o_tx_valid && i_tx_ready) begin
        hs_cnt++;
        act_q.push_back(o_tx_data);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte: got %02h with no byte expected", o_tx_data);
        end else check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
      end
      if (o_mem_read_en) begin
        rd_cnt++;
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_read: got addr %0h with no read expected", o_debug_addr);
        end else check("rd_addr", 32'(o_debug_addr), 32'(exp_addr_q.pop_front()));
      end
      if (o_done) begin
        done_cnt++;
        check("done_busy", 32'(o_busy), 32'd1);
      end
      if (o_busy) busy_cycles++;
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_abort = i_abort;
      prev_data  = o_tx_data;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    i_tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_tx_valid), 32'd0);
    check({tag, "_rden"}, 32'(o_mem_read_en), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  // Run one dump. abort_at/restart_at: handshake count that triggers the event, -1 for none.
  task automatic run_dump(input int abort_at, input int restart_at, input bit expect_full);
    int d0;
    int n;
    bit finished;
    load_expected();
    act_q.delete();
    hs_cnt = 0; rd_cnt = 0; busy_cycles = 0;
    d0 = done_cnt;
    finished = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    n = 0;
    while (!finished && n < 2000) begin
      if (done_cnt != d0) finished = 1'b1;
      else if (abort_at >= 0 && hs_cnt == abort_at) begin
        i_abort = 1'b1;
        i_tx_ready = 1'b0;
        step();
        i_abort = 1'b0;
        check_idle_outputs("abort");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (20) step();
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_hs", 32'(hs_cnt), 32'(abort_at));
        finished = 1'b1;
      end else begin
        i_start = (hs_cnt == restart_at);
        step();
        n++;
      end
    end
    i_start = 1'b0;
    if (!finished) begin
      total++; bad++;
      $display("FAIL timeout: got %0d handshakes, dump never ended", hs_cnt);
    end
    if (expect_full) begin
      step();
      check("end_idle_busy", 32'(o_busy), 32'd0);
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("hs_count", 32'(hs_cnt), 32'(EXP_BYTES));
      check("rd_pulses", 32'(rd_cnt), 32'(WORDS));
      check("exp_left", 32'(exp_q.size()), 32'd0);
      check("addr_left", 32'(exp_addr_q.size()), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_tx_ready = 1'b1;
    i_debug_data = 32'h0; rnd_mode = 1'b0;
    hs_cnt = 0; done_cnt = 0; rd_cnt = 0; busy_cycles = 0;
    prev_stall = 1'b0; prev_abort = 1'b0; prev_data = 8'h00;
    #1 rst = 1'b1;
    #2;
    check_idle_outputs("reset");
    check("reset_addr", 32'(o_debug_addr), 32'd0);
    check("reset_data", 32'(o_tx_data), 32'd0);
    check("reset_state_idle", 32'(o_dbg_state), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // start and abort together in IDLE: stays idle
    i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    check_idle_outputs("start_abort");

    // ramp memory, no backpressure
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'(i);
    run_dump(-1, -1, 1'b1);
    check("full_cycles", 32'(busy_cycles), 32'd97);
    if (act_q.size() >= EXP_BYTES) begin
      check("first_byte", 32'(act_q[0]), 32'h00);
      check("last_data_byte", 32'(act_q[63]), 32'h3F);
`ifdef MEM_DUMP_CHECKSUM_EN
      check("ramp_csum", 32'(act_q[64]), 32'h00);
`endif
    end else check("ramp_len", 32'(act_q.size()), 32'(EXP_BYTES));

    // random backpressure with an ignored start pulse mid-dump
    rnd_mode = 1'b1;
    run_dump(-1, 20, 1'b1);
    rnd_mode = 1'b0;

    // single non-zero byte
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
    mem[5] = 8'h3C;
    run_dump(-1, -1, 1'b1);
    if (act_q.size() >= EXP_BYTES) begin
      check("pos5_byte", 32'(act_q[5]), 32'h3C);
      check("pos4_byte", 32'(act_q[4]), 32'h00);
`ifdef MEM_DUMP_CHECKSUM_EN
      check("pos5_csum", 32'(act_q[64]), 32'h3C);
`endif
    end else check("pos5_len", 32'(act_q.size()), 32'(EXP_BYTES));

    // abort after 10 bytes, then a fresh dump from address 0
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'(i ^ 8'hA5);
    run_dump(10, -1, 1'b0);
    run_dump(-1, -1, 1'b1);

    // asynchronous reset in the middle of SEND
    load_expected();
    hs_cnt = 0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int n = 0; n < 500 && hs_cnt < 30; n++) step();
    check("pre_rst_valid", 32'(o_tx_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst_addr", 32'(o_debug_addr), 32'd0);
    check("midrst_data", 32'(o_tx_data), 32'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    step();
    check_idle_outputs("post_rst");
    run_dump(-1, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dump_ctrl.md
Name: mem_dump_ctrl

Overview:
- Debug-side sequencer for the data memory's debug read port.
- On command, walks the whole data memory one 32-bit word at a time, reads each word through the debug address/read-enable path, and streams it out as bytes over a valid/ready byte interface (feeds the UART TX block).
- Sits between the debug unit's command decoder and the data memory; has no interaction with the pipeline-side read/write ports.

Parameters:
- DATA_WIDTH, 32, debug data word width; fixed at 32 (4 bytes per word).
- MEM_SIZE, 64, data memory size in bytes; must be a multiple of 4.
- ADDR_WIDTH, $clog2(MEM_SIZE), byte address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  dump request; sampled in IDLE only.
- i_abort  in  1  cancel the dump in progress.
- o_debug_addr  out  ADDR_WIDTH  byte address to the memory debug port; always word-aligned.
- o_mem_read_en  out  1  debug read enable to the memory.
- i_debug_data  in  DATA_WIDTH  debug read data from the memory, little endian.
- o_tx_data  out  8  byte to transmitter.
- o_tx_valid  out  1  byte valid.
- i_tx_ready  in  1  transmitter accepts byte.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, immediate):
  - All outputs 0.
  - State IDLE; address counter 0; byte index 0; word register 0.
- States: IDLE, READ, WAIT, SEND, [CSUM], DONE.
- IDLE:
  - i_start=1 → READ; address counter cleared to 0.
  - i_start is ignored in any other state.
- READ (1 cycle):
  - o_mem_read_en=1; o_debug_addr=address counter.
  - Memory captures the word on the falling edge inside this cycle.
  - Next state WAIT.
- WAIT (1 cycle):
  - o_mem_read_en=0.
  - At the end of the cycle, latch i_debug_data into the word register; byte index=0; → SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = word byte [index] (index 0 = bits 7:0, sent first; little-endian order).
  - o_tx_data must stay stable while o_tx_valid=1 and i_tx_ready=0.
  - Handshake = valid&&ready on posedge. Index<3 → index+1, stay in SEND.
  - Index==3 and address==MEM_SIZE-4 → CSUM if enabled, else DONE.
  - Index==3 otherwise → address+4, → READ.
  - o_tx_valid is dropped for the READ/WAIT cycles between words.
- DONE (1 cycle): o_done=1, o_busy=1; → IDLE.
- Latency:
  - 2 cycles from the start edge to the first o_tx_valid (READ, WAIT).
  - Each word costs 2 cycles plus 4 handshakes.
  - Full dump without backpressure: MEM_SIZE/4 × 6 cycles + 1.
- Address counter:
  - Never exceeds MEM_SIZE-4; no wrap.
  - Word count = MEM_SIZE/4 exactly.
- i_abort:
  - Priority over everything, in any non-IDLE state.
  - Next cycle in IDLE with o_tx_valid=0 and o_mem_read_en=0; no o_done.
  - A byte handshaked in the abort cycle counts as sent; no further bytes follow.
- Simultaneous i_start and i_abort in IDLE: abort wins, stay IDLE.
- o_busy: 0 in IDLE, 1 in all other states, including DONE.

Optional Feature:
- Macro MEM_DUMP_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR accumulator clears on start and XORs in every handshaked data byte.
  - After the last data byte, state CSUM sends one extra byte = accumulator value (same valid/ready rules), then → DONE.
  - Total bytes sent = MEM_SIZE+1.
- When undefined: no CSUM state or accumulator; exactly MEM_SIZE bytes sent.

Test Plan:
- Memory model mem[i]=i, MEM_SIZE=64, i_tx_ready=1, pulse i_start → bytes 0x00..0x3F in order, 64 handshakes, one o_done pulse; with checksum enabled a 65th byte 0x00.
- Same preload, i_tx_ready random (~50%) → identical byte sequence, no byte lost or duplicated, o_tx_data constant while stalled.
- Memory all 0 except byte 5=0x3C, MEM_DUMP_CHECKSUM_EN defined → 64 data bytes with 0x3C at position 5, checksum byte 0x3C.
- i_abort asserted after byte 10 is accepted → IDLE next cycle, o_busy=0, no o_done, no further o_tx_valid; a fresh i_start restarts from address 0.
- i_start pulsed again mid-dump → ignored, sequence unchanged; rst asserted mid-SEND → all outputs 0 immediately, state IDLE.
- Check o_debug_addr sequence 0,4,…,60 with o_mem_read_en high exactly one cycle per word (16 pulses total).
